// File: rtl/pipe_robot_nav.sv
// Pipe-cleaning robot navigation controller: left-hand wall following,
// a fixed-length trash removal sequence, halt on exit, saturating move counter.
module pipe_robot_nav #(
  parameter int unsigned REMOVE_STEPS = 3,
  parameter int unsigned MOVE_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              front,
  output logic              turn,
  output logic              remove,
  output logic              done,
  output logic [MOVE_W-1:0] moves
);

  typedef enum logic [2:0] {
    SEEK,
    FOLLOW,
    POST_LEFT,
    TURN_R1,
    TURN_R2,
    REMOVE,
    DONE
  } state_t;

  localparam int unsigned CNT_W = $clog2(REMOVE_STEPS + 1);
  localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(REMOVE_STEPS);

  state_t           state, state_nx;
  state_t           ret_state, ret_nx;
  state_t           eval;
  logic [CNT_W-1:0] rem_cnt, rem_nx;
  logic             front_nx, turn_nx, remove_nx, done_nx;

  always_comb begin
    state_nx  = state;
    ret_nx    = ret_state;
    rem_nx    = rem_cnt;
    front_nx  = 1'b0;
    turn_nx   = 1'b0;
    remove_nx = 1'b0;
    done_nx   = 1'b0;

    // A finished removal is resolved by running the return state's rules
    // in this same step, so the robot never wastes an idle step.
    eval = state;
    if (state == REMOVE && rem_cnt == REM_LAST)
      eval = ret_state;

    case (eval)
      SEEK, FOLLOW, POST_LEFT: begin
        if (under) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else if (barrier) begin
          state_nx  = REMOVE;
          ret_nx    = (eval == SEEK) ? SEEK : FOLLOW;
          rem_nx    = CNT_W'(1);
          remove_nx = 1'b1;
        end else if (eval == FOLLOW && !left) begin
          state_nx = POST_LEFT;
          turn_nx  = 1'b1;
        end else if (!head) begin
          state_nx = (eval == SEEK && !left) ? SEEK : FOLLOW;
          front_nx = 1'b1;
        end else begin
          state_nx = TURN_R1;
          turn_nx  = 1'b1;
        end
      end
      TURN_R1: begin
        state_nx = TURN_R2;
        turn_nx  = 1'b1;
      end
      TURN_R2: begin
        state_nx = FOLLOW;
        turn_nx  = 1'b1;
      end
      REMOVE: begin
        rem_nx    = rem_cnt + CNT_W'(1);
        remove_nx = 1'b1;
      end
      DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        state_nx = SEEK;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SEEK;
      ret_state <= SEEK;
      rem_cnt   <= '0;
      front     <= 1'b0;
      turn      <= 1'b0;
      remove    <= 1'b0;
      done      <= 1'b0;
      moves     <= '0;
    end else if (step) begin
      state     <= state_nx;
      ret_state <= ret_nx;
      rem_cnt   <= rem_nx;
      front     <= front_nx;
      turn      <= turn_nx;
      remove    <= remove_nx;
      done      <= done_nx;
      if (front_nx && moves != '1)
        moves <= moves + MOVE_W'(1);
    end
  end

endmodule

// File: doc/pipe_robot_nav.md
Name: pipe_robot_nav

Overview:
- Navigation controller for the pipe-cleaning robot. It is the opposite end of the world simulator's sensor/actuator interface.
- It consumes the four sensor bits the world produces (head, left, under, barrier) and drives the three actuator bits the world consumes (front, turn, remove).
- It implements left-hand wall following, a three-step trash removal sequence and halt-on-exit, plus a move counter for board display.

Parameters:
- REMOVE_STEPS, 3: number of consecutive steps remove is held high; the world clears trash on the 3rd.
- MOVE_W, 16: width of the saturating move counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- step  input  1  single-cycle qualifier (one robot step); the FSM and outputs update only on edges where step=1.
- head  input  1  obstacle/wall directly ahead.
- left  input  1  wall on the robot's left.
- under  input  1  robot is on the exit cell.
- barrier  input  1  trash cell directly ahead.
- front  output  1  move one cell forward this step.
- turn  output  1  rotate 90 degrees counter-clockwise (left) this step.
- remove  output  1  trash-removal action this step.
- done  output  1  robot has reached the exit; sticky.
- moves  output  MOVE_W  count of steps with front=1.

Behaviour:
- Interface
  - reset is sampled only on rising clock; reset overrides step.
  - All outputs are registered. A decision is based on the sensors sampled at a step edge, appears after that edge, and holds until the next step edge.
  - When step=0: state, outputs and counters are held.
  - At most one of front/turn/remove is high in any cycle.
- Reset values: front=0, turn=0, remove=0, done=0, moves=0, state=SEEK, removal counter=0, return state=SEEK.
- A right turn is three consecutive turn steps: the issuing step plus TURN_R1 and TURN_R2.
- States and transitions on a step edge (priority top-down within each state):
  - SEEK (no wall acquired):
    - under=1 -> DONE.
    - barrier=1 -> REMOVE, return state=SEEK, remove=1.
    - left=1 -> apply FOLLOW rules this step.
    - head=0 -> front=1, stay in SEEK.
    - head=1 -> turn=1, go to TURN_R1.
  - FOLLOW:
    - under=1 -> DONE.
    - barrier=1 -> REMOVE, return state=FOLLOW, remove=1.
    - left=0 -> turn=1, go to POST_LEFT.
    - head=0 -> front=1, stay in FOLLOW.
    - head=1 -> turn=1, go to TURN_R1.
  - POST_LEFT (first step after a left turn; the left=0 rule is suppressed to prevent spinning):
    - under=1 -> DONE.
    - barrier=1 -> REMOVE, return state=FOLLOW.
    - head=0 -> front=1, go to FOLLOW.
    - head=1 -> turn=1, go to TURN_R1.
  - TURN_R1: turn=1, go to TURN_R2. Sensors are ignored.
  - TURN_R2: turn=1, go to FOLLOW. Sensors are ignored.
  - REMOVE:
    - remove stays 1 for exactly REMOVE_STEPS step edges in total, counted from entry; the counter runs from 1 to REMOVE_STEPS.
    - On the edge after the last removal step, the state re-evaluates the return state's rules using current sensors. Outputs on that edge follow those rules; remove falls to 0 unless barrier is still 1, in which case a fresh removal starts.
    - under is ignored until the removal completes.
  - DONE: front, turn and remove are 0 and done=1. Absorbing state; only reset leaves it.
- moves:
  - Increments on each step edge where the newly registered front=1.
  - Saturates at all-ones (no wrap).
  - Not reset by DONE.
- Reset mid-operation (REMOVE, TURN_R*, DONE): next edge returns to the reset values; a partial removal or turn is abandoned.
- Simultaneous events: under beats barrier beats left beats head, per the priority lists above.
- step asserted in the same cycle as reset: ignored.

Test Plan:
- Reset, then 2 step pulses with head=0, left=0, under=0, barrier=0 -> front=1 after each pulse, turn=0, remove=0, moves=2; step=0 for 10 cycles -> all outputs unchanged.
- SEEK with head=1, left=0, then 3 steps (sensors toggled randomly on the 2nd and 3rd) -> turn=1 on all 3; 4th step with head=0, left=1 -> front=1 (FOLLOW reached).
- FOLLOW with barrier=1 for 3 steps, then barrier=0, head=0, left=1 on the 4th -> remove=1 exactly 3 steps with front=0 and turn=0, then front=1 and moves incremented by 1.
- FOLLOW with left=0 -> turn=1; next step left=0, head=0 -> front=1 (no second turn); next step left=1, head=0 -> front=1.
- under=1 with barrier=1 on the same step -> done=1 and all motion outputs 0; 5 more steps with any sensors -> unchanged; reset -> done=0.
- Reset asserted on the 2nd remove step -> remove=0 and state=SEEK after that edge; next step with head=0 -> front=1. Separately, preload 0xFFFE moves via steps -> the counter saturates at 0xFFFF.
